// File: rtl/q_chain_loader_if.sv
// Load handshake and serial chain-control signals between a Q_FRAG chain loader and its surroundings.
// Signal names follow the chain-loader pinout.
interface q_chain_loader_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] LD_DATA;
   logic             LD_VALID;
   logic             LD_READY;
   logic             CHAIN_QDI;
   logic             CHAIN_QEN;
   logic             CHAIN_CDS;
   logic             CHAIN_QRT;
   logic             CHAIN_AQZ;
   logic             BUSY;
   logic             DONE;
   logic             MISMATCH;

   modport slave (
      input  LD_DATA, LD_VALID, CHAIN_AQZ,
      output LD_READY, CHAIN_QDI, CHAIN_QEN, CHAIN_CDS, CHAIN_QRT, BUSY, DONE, MISMATCH
   );

   modport master (
      output LD_DATA, LD_VALID, CHAIN_AQZ,
      input  LD_READY, CHAIN_QDI, CHAIN_QEN, CHAIN_CDS, CHAIN_QRT, BUSY, DONE, MISMATCH
   );
endinterface

// File: rtl/q_chain_loader.sv
// Clears a Q_FRAG shift chain, shifts a word in MSB-first, then re-shifts it while reading the
// last cell's AQZ back and flagging any bit that does not match.
//
// state  | meaning
// RST    | held in reset; every output low
// IDLE   | ready for a word; chain retained (QEN=0)
// CLEAR  | QRT pulsed for CLR_CYCLES cycles
// SHIFT  | WIDTH cycles shifting the word in, MSB first
// VERIFY | WIDTH cycles re-shifting the word while comparing AQZ
// DONE   | one-cycle completion pulse, MISMATCH valid
module q_chain_loader #(
   parameter int WIDTH      = 8,
   parameter int CLR_CYCLES = 2
) (
   input  logic                QCK,
   input  logic                QRTN,
   q_chain_loader_if.slave     bus
);
   localparam int CNT_MAX = (WIDTH > CLR_CYCLES) ? WIDTH : CLR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_RST, ST_IDLE, ST_CLEAR, ST_SHIFT, ST_VERIFY, ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             err_q, err_d;
   logic             ld_ready_q, ld_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             mismatch_q, mismatch_d;
   logic             qdi_q, qdi_d;
   logic             qen_q, qen_d;
   logic             cds_q, cds_d;
   logic             qrt_q, qrt_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      err_d      = err_q;
      mismatch_d = mismatch_q;

      case (state_q)
         ST_RST: state_d = ST_IDLE;
         ST_IDLE: begin
            if (bus.LD_VALID && ld_ready_q) begin
               state_d    = ST_CLEAR;
               sh_d       = bus.LD_DATA;
               err_d      = 1'b0;
               mismatch_d = 1'b0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CLR_LAST) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            cnt_d = cnt_q + CNT_W'(1);
            sh_d  = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
            if (cnt_q == BIT_LAST) state_d = ST_VERIFY;
         end
         ST_VERIFY: begin
            cnt_d = cnt_q + CNT_W'(1);
            sh_d  = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
            // The rotating word's MSB is the bit currently sitting in the last cell; X/Z counts as bad.
            if (bus.CHAIN_AQZ !== sh_q[WIDTH-1]) err_d = 1'b1;
            if (cnt_q == BIT_LAST) begin
               state_d    = ST_DONE;
               mismatch_d = err_d;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_RST;
      endcase

      if (state_d != state_q) cnt_d = '0;

      ld_ready_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      qdi_d      = 1'b0;
      qen_d      = 1'b0;
      cds_d      = 1'b1;
      qrt_d      = 1'b0;
      case (state_d)
         ST_RST:   cds_d = 1'b0;
         ST_IDLE:  ld_ready_d = 1'b1;
         ST_CLEAR: begin
            busy_d = 1'b1;
            qrt_d  = 1'b1;
         end
         ST_SHIFT, ST_VERIFY: begin
            busy_d = 1'b1;
            qen_d  = 1'b1;
            qdi_d  = sh_d[WIDTH-1];
         end
         ST_DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: cds_d = 1'b0;
      endcase
   end

   always_ff @(posedge QCK or negedge QRTN) begin
      if (!QRTN) begin
         state_q    <= ST_RST;
         cnt_q      <= '0;
         sh_q       <= '0;
         err_q      <= 1'b0;
         ld_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mismatch_q <= 1'b0;
         qdi_q      <= 1'b0;
         qen_q      <= 1'b0;
         cds_q      <= 1'b0;
         qrt_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         err_q      <= err_d;
         ld_ready_q <= ld_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mismatch_q <= mismatch_d;
         qdi_q      <= qdi_d;
         qen_q      <= qen_d;
         cds_q      <= cds_d;
         qrt_q      <= qrt_d;
      end
   end

   assign bus.LD_READY  = ld_ready_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.MISMATCH  = mismatch_q;
   assign bus.CHAIN_QDI = qdi_q;
   assign bus.CHAIN_QEN = qen_q;
   assign bus.CHAIN_CDS = cds_q;
   assign bus.CHAIN_QRT = qrt_q;
endmodule
